// File: rtl/memory_arbiter_rr_if.sv
// rtl/memory_arbiter_rr_if.sv - RAM state type and core/RAM bus bundle for the multi-core arbiter
package memory_arbiter_rr_pkg;
  typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_t;
endpackage

interface memory_arbiter_rr_if #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
);
  import memory_arbiter_rr_pkg::*;

  logic [CPUS-1:0]        iREN;
  logic [CPUS-1:0]        dREN;
  logic [CPUS-1:0]        dWEN;
  logic [CPUS*WORD_W-1:0] iaddr;
  logic [CPUS*WORD_W-1:0] daddr;
  logic [CPUS*WORD_W-1:0] dstore;
  logic [CPUS-1:0]        iwait;
  logic [CPUS-1:0]        dwait;
  logic [CPUS*WORD_W-1:0] iload;
  logic [CPUS*WORD_W-1:0] dload;
  logic                   ramREN;
  logic                   ramWEN;
  logic [WORD_W-1:0]      ramaddr;
  logic [WORD_W-1:0]      ramstore;
  logic [WORD_W-1:0]      ramload;
  ramstate_t              ramstate;

  // arbiter side
  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  // cores plus RAM model side
  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter_rr.sv
// rtl/memory_arbiter_rr.sv - round-robin arbiter of per-core I/D ports onto one RAM port
module memory_arbiter_rr #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input logic                CLK,
  input logic                nRST,
  memory_arbiter_rr_if.slave bus
);
  import memory_arbiter_rr_pkg::*;

  localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   gnt_cpu_q, gnt_cpu_d;
  logic            gnt_d_q, gnt_d_d;
  logic [CPUS-1:0] d_pend;
  logic            found;
  logic            req_ok;
  int              idx;

  assign d_pend    = bus.dREN | bus.dWEN;
  assign bus.iload = {CPUS{bus.ramload}};
  assign bus.dload = {CPUS{bus.ramload}};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      gnt_cpu_q <= '0;
      gnt_d_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt_cpu_q <= gnt_cpu_d;
      gnt_d_q   <= gnt_d_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    gnt_cpu_d    = gnt_cpu_q;
    gnt_d_d      = gnt_d_q;
    found        = 1'b0;
    req_ok       = 1'b0;
    idx          = 0;
    bus.iwait    = '1;
    bus.dwait    = '1;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;

    case (state_q)
      S_IDLE: begin
        // first pending core at or after rr_q wins; data beats fetch inside a core
        for (int i = 0; i < CPUS; i++) begin
          idx = (int'(rr_q) + i) % CPUS;
          if (!found && (d_pend[idx] || bus.iREN[idx])) begin
            found     = 1'b1;
            gnt_cpu_d = CW'(idx);
            gnt_d_d   = d_pend[idx];
          end
        end
        if (found) state_d = S_BUSY;
      end

      S_BUSY: begin
        if (gnt_d_q) begin
          req_ok       = d_pend[gnt_cpu_q];
          bus.ramWEN   = bus.dWEN[gnt_cpu_q];
          bus.ramREN   = bus.dREN[gnt_cpu_q] & ~bus.dWEN[gnt_cpu_q];
          bus.ramaddr  = bus.daddr[gnt_cpu_q*WORD_W +: WORD_W];
          bus.ramstore = bus.dstore[gnt_cpu_q*WORD_W +: WORD_W];
        end else begin
          req_ok       = bus.iREN[gnt_cpu_q];
          bus.ramREN   = 1'b1;
          bus.ramaddr  = bus.iaddr[gnt_cpu_q*WORD_W +: WORD_W];
        end

        // a dropped request aborts without completing or advancing the pointer
        if (!req_ok) begin
          state_d = S_IDLE;
        end else if (bus.ramstate == RAM_ACCESS) begin
          if (gnt_d_q) bus.dwait[gnt_cpu_q] = 1'b0;
          else         bus.iwait[gnt_cpu_q] = 1'b0;
          rr_d    = (gnt_cpu_q == CW'(CPUS - 1)) ? '0 : gnt_cpu_q + 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_memory_arbiter_rr.sv
// tb/tb_memory_arbiter_rr.sv - scoreboard bench for memory_arbiter_rr with a latency-programmable RAM model
module tb_memory_arbiter_rr;
  import memory_arbiter_rr_pkg::*;

  localparam logic [31:0] LOAD_KEY = 32'hA5A5_0000;

  typedef struct {
    logic        d;
    int          cpu;
    logic [31:0] addr;
    logic [31:0] store;
    logic        wen;
    logic [31:0] load;
  } exp_t;

  logic CLK;
  logic nRST;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat      = 2;
  bit   err      = 0;
  int   cnt      = 0;
  exp_t sb[$];

  memory_arbiter_rr_if #(.CPUS(2), .WORD_W(32)) bus ();

  memory_arbiter_rr #(.CPUS(2), .WORD_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic push(input logic d, input int cpu, input logic [31:0] addr,
                      input logic [31:0] store, input logic wen, input logic [31:0] load);
    exp_t e;
    e.d = d; e.cpu = cpu; e.addr = addr; e.store = store; e.wen = wen; e.load = load;
    sb.push_back(e);
  endtask

  task automatic observe(input logic d, input int cpu);
    exp_t        e;
    logic [31:0] ld;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_done: got %s%0d completion, expected none", d ? "d" : "i", cpu);
    end else begin
      e  = sb.pop_front();
      ld = d ? bus.dload[cpu*32 +: 32] : bus.iload[cpu*32 +: 32];
      check("done_cpu", cpu, e.cpu);
      check("done_kind", {31'b0, d}, {31'b0, e.d});
      check("ramaddr", bus.ramaddr, e.addr);
      check("ramWEN", {31'b0, bus.ramWEN}, {31'b0, e.wen});
      check("ramREN", {31'b0, bus.ramREN}, {31'b0, ~e.wen});
      if (e.wen) check("ramstore", bus.ramstore, e.store);
      else       check("load", ld, e.load);
    end
  endtask

  // RAM model: counts enabled cycles and reports ACCESS on the lat-th one
  always @(posedge CLK) begin
    #1;
    if (bus.ramREN || bus.ramWEN) cnt++;
    else                          cnt = 0;
    if (cnt != 0 && cnt == lat) bus.ramstate = RAM_ACCESS;
    else if (cnt != 0 && err)   bus.ramstate = RAM_ERROR;
    else if (cnt != 0)          bus.ramstate = RAM_BUSY;
    else                        bus.ramstate = RAM_FREE;
    bus.ramload = bus.ramREN ? (bus.ramaddr ^ LOAD_KEY) : 32'h0;
  end

  // monitor: every wait=0 cycle is a completion matched against the scoreboard
  always @(negedge CLK) begin
    if (nRST && (~bus.iwait != 2'b00 || ~bus.dwait != 2'b00)) begin
      check("one_done", $countones(~bus.iwait) + $countones(~bus.dwait), 1);
      for (int c = 0; c < 2; c++) begin
        if (!bus.iwait[c]) observe(1'b0, c);
        if (!bus.dwait[c]) observe(1'b1, c);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_done(input logic d, input int cpu);
    bit hit = 0;
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge CLK);
      hit = d ? !bus.dwait[cpu] : !bus.iwait[cpu];
    end
    check("done_timeout", {31'b0, hit}, 32'd1);
  endtask

  task automatic wait_ram();
    bit hit = 0;
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge CLK);
      hit = bus.ramREN || bus.ramWEN;
    end
    check("ram_timeout", {31'b0, hit}, 32'd1);
  endtask

  initial begin
    nRST         = 1'b0;
    bus.iREN     = '0;
    bus.dREN     = '0;
    bus.dWEN     = '0;
    bus.iaddr    = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = RAM_FREE;

    #3;
    check("rst_iwait", {30'b0, bus.iwait}, 32'h3);
    check("rst_dwait", {30'b0, bus.dwait}, 32'h3);
    check("rst_ramREN", {31'b0, bus.ramREN}, 32'h0);
    check("rst_ramWEN", {31'b0, bus.ramWEN}, 32'h0);
    check("rst_ramaddr", bus.ramaddr, 32'h0);
    check("rst_ramstore", bus.ramstore, 32'h0);
    step();
    step();
    nRST = 1'b1;

    // single instruction fetch, ACCESS on the second BUSY cycle
    lat = 2;
    bus.iaddr[31:0] = 32'h40;
    push(1'b0, 0, 32'h40, 32'h0, 1'b0, 32'hA5A5_0040);
    bus.iREN[0] = 1'b1;
    wait_done(1'b0, 0);
    step();
    bus.iREN[0] = 1'b0;

    // data and fetch together on core0: data first
    bus.daddr[31:0] = 32'h100;
    bus.iaddr[31:0] = 32'h0;
    push(1'b1, 0, 32'h100, 32'h0, 1'b0, 32'hA5A5_0100);
    push(1'b0, 0, 32'h0, 32'h0, 1'b0, 32'hA5A5_0000);
    bus.dREN[0] = 1'b1;
    bus.iREN[0] = 1'b1;
    wait_done(1'b1, 0);
    step();
    bus.dREN[0] = 1'b0;
    wait_done(1'b0, 0);
    step();
    bus.iREN[0] = 1'b0;

    // core1 read aborted before ACCESS; pointer must stay at 1
    lat = 8;
    bus.daddr[63:32] = 32'h280;
    bus.dREN[1] = 1'b1;
    wait_ram();
    check("abort_ramaddr", bus.ramaddr, 32'h280);
    step();
    bus.dREN[1] = 1'b0;
    @(negedge CLK);
    check("abort_ramREN", {31'b0, bus.ramREN}, 32'h0);
    check("abort_dwait", {30'b0, bus.dwait}, 32'h3);
    step();
    step();
    lat = 2;
    bus.daddr = {32'h200, 32'h180};
    push(1'b1, 1, 32'h200, 32'h0, 1'b0, 32'hA5A5_0200);
    push(1'b1, 0, 32'h180, 32'h0, 1'b0, 32'hA5A5_0180);
    bus.dREN = 2'b11;
    wait_done(1'b1, 1);
    step();
    bus.dREN[1] = 1'b0;
    wait_done(1'b1, 0);
    step();
    bus.dREN[0] = 1'b0;

    // both cores writing continuously from a fresh pointer: 0,1,0,1
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    bus.daddr  = {32'h20, 32'h10};
    bus.dstore = {32'h2222_2222, 32'h1111_1111};
    push(1'b1, 0, 32'h10, 32'h1111_1111, 1'b1, 32'h0);
    push(1'b1, 1, 32'h20, 32'h2222_2222, 1'b1, 32'h0);
    push(1'b1, 0, 32'h10, 32'h1111_1111, 1'b1, 32'h0);
    push(1'b1, 1, 32'h20, 32'h2222_2222, 1'b1, 32'h0);
    bus.dWEN = 2'b11;
    wait_done(1'b1, 0);
    wait_done(1'b1, 1);
    wait_done(1'b1, 0);
    wait_done(1'b1, 1);
    step();
    bus.dWEN = 2'b00;

    // ten ERROR cycles hold everything, ACCESS on the eleventh
    lat = 11;
    err = 1;
    bus.daddr[31:0] = 32'h300;
    push(1'b1, 0, 32'h300, 32'h0, 1'b0, 32'hA5A5_0300);
    bus.dREN[0] = 1'b1;
    wait_ram();
    for (int i = 0; i < 10; i++) begin
      check("err_waits", {28'b0, bus.iwait, bus.dwait}, 32'hF);
      check("err_ramaddr", bus.ramaddr, 32'h300);
      check("err_ramREN", {31'b0, bus.ramREN}, 32'h1);
      if (i < 9) @(negedge CLK);
    end
    wait_done(1'b1, 0);
    step();
    bus.dREN[0] = 1'b0;
    err = 0;

    // reset mid-BUSY on core1 write, then restart from core0
    lat = 8;
    bus.daddr[63:32]  = 32'h500;
    bus.dstore[63:32] = 32'h5555_5555;
    bus.dWEN[1] = 1'b1;
    wait_ram();
    #2;
    nRST = 1'b0;
    #1;
    check("rst_busy_ramREN", {31'b0, bus.ramREN}, 32'h0);
    check("rst_busy_ramWEN", {31'b0, bus.ramWEN}, 32'h0);
    check("rst_busy_waits", {28'b0, bus.iwait, bus.dwait}, 32'hF);
    check("rst_busy_ramaddr", bus.ramaddr, 32'h0);
    lat = 2;
    bus.daddr[31:0] = 32'h600;
    bus.dREN[0] = 1'b1;
    push(1'b1, 0, 32'h600, 32'h0, 1'b0, 32'hA5A5_0600);
    push(1'b1, 1, 32'h500, 32'h5555_5555, 1'b1, 32'h0);
    step();
    nRST = 1'b1;
    wait_done(1'b1, 0);
    step();
    bus.dREN[0] = 1'b0;
    wait_done(1'b1, 1);
    step();
    bus.dWEN[1] = 1'b0;

    step();
    step();
    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
